i2c_slave_rx: RTL
=================

# i2c_slave_rx

Receiving end of the team's 4-bit I2C link: samples the bus driven by the master (`scl`, `sda`), detects START/STOP, shifts in a 4-bit address and 4-bit message nibbles, and pulls SDA low to acknowledge each nibble. Received nibbles are presented on a parallel output with a one-cycle valid strobe for downstream logic. It runs on the system clock and oversamples SCL; it never drives SCL.

## Interface
- `SLAVE_ADDR`, 4'b1100: address this slave answers to.
- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `scl`  in  1  bus clock from the master; asynchronous to `clk`.
- `sda_in`  in  1  sampled bus data line.
- `sda_oe`  out  1  open-drain enable; 1 pulls SDA low, 0 releases it.
- `ack`  out  1  high while this block is driving an ACK; equals `sda_oe`.
- `data_out`  out  4  last received message nibble.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates.
- `addr_match`  out  1  high from a matched address until STOP or the next START.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- `scl` and `sda_in` each pass through a 2-flop synchronizer and a third history flop; edges and START/STOP are detected from sync stage 2 against the history flop.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. START/STOP cannot occur on the same sample as an SCL edge; if they do, the SCL edge wins.
- Bits are sampled on rising SCL edges, MSB first. A 3-bit counter `bitcnt` counts 0..3.
- States:
  - IDLE: waits for START -> ADDR, `bitcnt`=0.
  - ADDR: shifts 4 bits. After the 4th bit: match -> ADDR_ACK and set `addr_match`; mismatch -> WAIT_STOP.
  - ADDR_ACK: on the next falling SCL edge assert `sda_oe`; hold through the following rising edge; release on the following falling edge -> DATA, `bitcnt`=0.
  - DATA: shifts 4 bits. After the 4th bit -> DATA_ACK.
  - DATA_ACK: on the falling edge that asserts `sda_oe`, load the shift register into `data_out` and pulse `data_valid`. Release on the next falling edge -> DATA, so consecutive nibbles are accepted until STOP.
  - WAIT_STOP: ignores bits and never drives SDA.
- STOP in any state -> IDLE. `sda_oe`, `ack` and `addr_match` clear; `data_out` holds.
- A repeated START in any non-IDLE state -> ADDR, `bitcnt`=0, `addr_match` cleared, `sda_oe` released.
- A STOP or START arriving mid-nibble discards the partial nibble and produces no `data_valid`.
- `sda_in` is not sampled while `sda_oe`=1.

## Timing
- Reset values: `sda_oe`=0, `ack`=0, `data_out`=4'b0000, `data_valid`=0, `addr_match`=0, `busy`=0. State is IDLE and all synchronizer flops are 1 (idle bus).
- Reset asserted mid-transfer releases SDA asynchronously, in the same cycle.
- All outputs are registered.
- A raw `scl`/`sda_in` transition is acted on by the FSM 3 `clk` cycles later: 2 for sync, 1 for the registered FSM update. `sda_oe` therefore asserts and deasserts 3 cycles after the corresponding raw SCL falling edge.
- `data_valid` is exactly 1 cycle wide and coincides with the cycle `sda_oe` rises in DATA_ACK.
- The bus contract requires SCL high and low phases of at least 8 `clk` cycles each, and SDA setup/hold of at least 4 `clk` cycles around SCL rising edges.

## Test plan
- Reset then idle bus: all outputs at reset values, `busy`=0; no SCL activity produces no state change.
- START, address 1100, message 0101, STOP: `sda_oe` high across both ACK clock pulses; `data_out`=0101 with one `data_valid` pulse 3 cycles after the 9th-bit falling edge; `busy` low after STOP.
- Address 1010 (mismatch): `sda_oe` never asserts, `addr_match`=0, no `data_valid`, WAIT_STOP until STOP.
- Matched address followed by nibbles 0101 and 1110 before STOP: two `data_valid` pulses, `data_out` ends at 1110, two data ACKs issued.
- STOP after 2 data bits, then a full frame 1100/0011: the first partial nibble produces no `data_valid`; the second frame yields `data_out`=0011.
- Repeated START during DATA, and `reset` asserted while `sda_oe`=1: the FSM restarts in ADDR; under reset `sda_oe` drops immediately and all outputs return to reset values.

Source files
------------

// File: rtl/i2c_slave_rx.sv
// Receive side of the 4-bit I2C link: synchronizes SCL/SDA, decodes START/STOP,
// matches a 4-bit address, then accepts 4-bit nibbles with an ACK after each.
module i2c_slave_rx #(
   parameter logic [3:0] SLAVE_ADDR = 4'b1100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       ack,
   output logic [3:0] data_out,
   output logic       data_valid,
   output logic       addr_match,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_DATA,
      S_DATA_ACK,
      S_WAIT_STOP
   } state_t;

   // Two sync stages plus one history flop per line; all reset to the idle-bus level.
   logic scl_s1_q, scl_s2_q, scl_h_q;
   logic sda_s1_q, sda_s2_q, sda_h_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
         scl_h_q  <= 1'b1;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
         sda_h_q  <= 1'b1;
      end else begin
         scl_s1_q <= scl;
         scl_s2_q <= scl_s1_q;
         scl_h_q  <= scl_s2_q;
         sda_s1_q <= sda_in;
         sda_s2_q <= sda_s1_q;
         sda_h_q  <= sda_s2_q;
      end
   end

   logic scl_rise, scl_fall, start_det, stop_det;

   // START/STOP require SCL high on both samples, so an SCL edge always wins.
   assign scl_rise  =  scl_s2_q & ~scl_h_q;
   assign scl_fall  = ~scl_s2_q &  scl_h_q;
   assign start_det =  scl_s2_q &  scl_h_q &  sda_h_q & ~sda_s2_q;
   assign stop_det  =  scl_s2_q &  scl_h_q & ~sda_h_q &  sda_s2_q;

   state_t     state_q, state_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [3:0] shift_q, shift_d;
   logic [3:0] dout_q, dout_d;
   logic       oe_q, oe_d;
   logic       match_q, match_d;
   logic       dv_q, dv_d;
   logic       busy_q, busy_d;
   logic [3:0] shift_in;

   assign shift_in = {shift_q[2:0], sda_s2_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         bitcnt_q <= 3'd0;
         shift_q  <= 4'd0;
         dout_q   <= 4'd0;
         oe_q     <= 1'b0;
         match_q  <= 1'b0;
         dv_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         dout_q   <= dout_d;
         oe_q     <= oe_d;
         match_q  <= match_d;
         dv_q     <= dv_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      dout_d   = dout_q;
      oe_d     = oe_q;
      match_d  = match_q;
      dv_d     = 1'b0;

      if (start_det) begin
         state_d  = S_ADDR;
         bitcnt_d = 3'd0;
         match_d  = 1'b0;
         oe_d     = 1'b0;
      end else if (stop_det) begin
         state_d = S_IDLE;
         oe_d    = 1'b0;
         match_d = 1'b0;
      end else begin
         case (state_q)
            S_ADDR: begin
               if (scl_rise && !oe_q) begin
                  shift_d = shift_in;
                  if (bitcnt_q == 3'd3) begin
                     if (shift_in == SLAVE_ADDR) begin
                        state_d = S_ADDR_ACK;
                        match_d = 1'b1;
                     end else begin
                        state_d = S_WAIT_STOP;
                     end
                  end else begin
                     bitcnt_d = bitcnt_q + 3'd1;
                  end
                end
            end
            // First falling edge grabs SDA, the next one lets go.
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_d = 1'b1;
                  end else begin
                     oe_d     = 1'b0;
                     state_d  = S_DATA;
                     bitcnt_d = 3'd0;
                  end
               end
            end
            S_DATA: begin
               if (scl_rise && !oe_q) begin
                  shift_d = shift_in;
                  if (bitcnt_q == 3'd3) begin
                     state_d = S_DATA_ACK;
                  end else begin
                     bitcnt_d = bitcnt_q + 3'd1;
                  end
               end
            end
            S_DATA_ACK: begin
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_d   = 1'b1;
                     dout_d = shift_q;
                     dv_d   = 1'b1;
                  end else begin
                     oe_d     = 1'b0;
                     state_d  = S_DATA;
                     bitcnt_d = 3'd0;
                  end
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   assign sda_oe     = oe_q;
   assign ack        = oe_q;
   assign data_out   = dout_q;
   assign data_valid = dv_q;
   assign addr_match = match_q;
   assign busy       = busy_q;

endmodule
